// File: rtl/seg_pkg.sv
// Shared types and constants for the numeric seven-segment display converter.
// Segment patterns are active-low, ordered {a,b,c,d,e,f,g} with segment a in bit 6.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_EMIT   = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, // 0
        7'b1001111, // 1
        7'b0010010, // 2
        7'b0000110, // 3
        7'b1001100, // 4
        7'b0100100, // 5
        7'b0100000, // 6
        7'b0001111, // 7
        7'b0000000, // 8
        7'b0000100, // 9
        7'b0001000, // A
        7'b1100000, // b
        7'b1110010, // c
        7'b1000010, // d
        7'b0110000, // E
        7'b0111000  // F
    };

endpackage

// File: rtl/seven_segment.sv
// Combinational hex digit to active-low seven-segment encoder.
module seven_segment
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/seg_numeric_display.sv
// Converts a binary operand to DIGITS seven-segment digits in radix 10 or 16,
// one digit per EMIT, with decimal digits produced by a WIDTH-step restoring divide by 10.
module seg_numeric_display
    import seg_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      num,
    input  logic                  hex_mode,
    input  logic                  signed_mode,
    input  logic                  blank_lz,
    output logic                  out_valid,
    output logic [7*DIGITS-1:0]   segs,
    output logic                  sign_n,
    output logic                  overflow
);

    localparam int STEP_W = $clog2(WIDTH + 1);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    val_q, val_d;
    logic [3:0]          rem_q, rem_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                hex_q, hex_d;
    logic                neg_q, neg_d;
    logic                blz_q, blz_d;
    logic [3:0]          dig_q [DIGITS];
    logic [3:0]          dig_d [DIGITS];

    logic                out_valid_q, out_valid_d;
    logic                sign_n_q, sign_n_d;
    logic                overflow_q, overflow_d;
    logic [3:0]          disp_dig_q [DIGITS];
    logic [3:0]          disp_dig_d [DIGITS];
    logic [DIGITS-1:0]   disp_blank_q, disp_blank_d;

    logic [4:0]          rem_shift;
    logic [4:0]          rem_sub;
    logic [3:0]          new_digit;
    logic [WIDTH-1:0]    val_after;
    logic                last_digit;
    logic                lz_run;

    // Held low through the out_valid cycle so a back-to-back request waits one edge.
    assign in_ready = (state_q == ST_IDLE) && !out_valid_q;

    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    always_comb begin
        state_d      = state_q;
        val_d        = val_q;
        rem_d        = rem_q;
        step_d       = step_q;
        idx_d        = idx_q;
        hex_d        = hex_q;
        neg_d        = neg_q;
        blz_d        = blz_q;
        dig_d        = dig_q;
        out_valid_d  = 1'b0;
        sign_n_d     = sign_n_q;
        overflow_d   = overflow_q;
        disp_dig_d   = disp_dig_q;
        disp_blank_d = disp_blank_q;

        rem_shift  = {rem_q, val_q[WIDTH-1]};
        rem_sub    = rem_shift - 5'd10;
        new_digit  = hex_q ? val_q[3:0] : rem_q;
        val_after  = hex_q ? (val_q >> 4) : val_q;
        last_digit = (idx_q == IDX_W'(DIGITS - 1));
        lz_run     = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    hex_d   = hex_mode;
                    neg_d   = signed_mode && num[WIDTH-1];
                    blz_d   = blank_lz;
                    val_d   = (signed_mode && num[WIDTH-1]) ? (~num + WIDTH'(1)) : num;
                    rem_d   = 4'd0;
                    step_d  = '0;
                    idx_d   = '0;
                    state_d = hex_mode ? ST_EMIT : ST_DIVIDE;
                end
            end

            ST_DIVIDE: begin
                // No borrow means the shifted partial remainder reached 10.
                if (!rem_sub[4]) begin
                    rem_d = rem_sub[3:0];
                    val_d = {val_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[3:0];
                    val_d = {val_q[WIDTH-2:0], 1'b0};
                end
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(WIDTH - 1)) begin
                    state_d = ST_EMIT;
                end
            end

            ST_EMIT: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        dig_d[i] = new_digit;
                    end
                end
                val_d  = val_after;
                rem_d  = 4'd0;
                step_d = '0;

                if (last_digit) begin
                    state_d     = ST_IDLE;
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    sign_n_d    = ~neg_q;
                    overflow_d  = |val_after;
                    disp_dig_d  = dig_d;
                    // A digit is a leading zero when it and everything above it is zero.
                    for (int i = DIGITS - 1; i >= 1; i--) begin
                        lz_run          = lz_run && (dig_d[i] == 4'd0);
                        disp_blank_d[i] = blz_q && lz_run;
                    end
                    disp_blank_d[0] = 1'b0;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = hex_q ? ST_EMIT : ST_DIVIDE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            val_q        <= '0;
            rem_q        <= 4'd0;
            step_q       <= '0;
            idx_q        <= '0;
            hex_q        <= 1'b0;
            neg_q        <= 1'b0;
            blz_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            sign_n_q     <= 1'b1;
            overflow_q   <= 1'b0;
            disp_blank_q <= '1;
            // NOTE: the digit arrays are a handful of flops, not a RAM, so they are
            // reset explicitly; that also makes the idle display fully blank.
            for (int i = 0; i < DIGITS; i++) begin
                dig_q[i]      <= 4'd0;
                disp_dig_q[i] <= 4'd0;
            end
        end else begin
            state_q      <= state_d;
            val_q        <= val_d;
            rem_q        <= rem_d;
            step_q       <= step_d;
            idx_q        <= idx_d;
            hex_q        <= hex_d;
            neg_q        <= neg_d;
            blz_q        <= blz_d;
            dig_q        <= dig_d;
            out_valid_q  <= out_valid_d;
            sign_n_q     <= sign_n_d;
            overflow_q   <= overflow_d;
            disp_dig_q   <= disp_dig_d;
            disp_blank_q <= disp_blank_d;
        end
    end

    // Display digits are encoded from the registers committed on the out_valid edge.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [6:0] enc;

        seven_segment u_seven_segment (
            .digit (disp_dig_q[g]),
            .seg   (enc)
        );

        assign segs[7*g +: 7] = overflow_q      ? SEG_DASH  :
                                disp_blank_q[g] ? SEG_BLANK : enc;
    end

    assign out_valid = out_valid_q;
    assign sign_n    = sign_n_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_seg_numeric_display.sv
// Self-checking bench for seg_numeric_display (WIDTH=32, DIGITS=8): directed corner
// cases, randomized operands against an arithmetic reference model, and mid-run reset.
module tb_seg_numeric_display;

    localparam int WIDTH   = 32;
    localparam int DIGITS  = 8;
    localparam int LAT_DEC = DIGITS * (WIDTH + 1);
    localparam int LAT_HEX = DIGITS;

    localparam logic [6:0] ENC [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     num;
    logic                 hex_mode;
    logic                 signed_mode;
    logic                 blank_lz;
    logic                 out_valid;
    logic [7*DIGITS-1:0]  segs;
    logic                 sign_n;
    logic                 overflow;

    int tests = 0;
    int fails = 0;

    seg_numeric_display #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .num         (num),
        .hex_mode    (hex_mode),
        .signed_mode (signed_mode),
        .blank_lz    (blank_lz),
        .out_valid   (out_valid),
        .segs        (segs),
        .sign_n      (sign_n),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: repeated division of the magnitude by the radix, blanking by comparing
    // the magnitude against radix^i, overflow when anything is left after DIGITS digits.
    function automatic logic [7*DIGITS-1:0] model(input logic [WIDTH-1:0] n, input bit hx,
                                                  input bit sg, input bit bz,
                                                  output bit ovf, output bit sn);
        longint unsigned mag, work, radix, pw;
        logic [7*DIGITS-1:0] res;
        bit neg;
        neg   = sg && n[WIDTH-1];
        mag   = neg ? ((64'd1 << WIDTH) - 64'(n)) : 64'(n);
        radix = hx ? 64'd16 : 64'd10;
        work  = mag;
        pw    = 64'd1;
        res   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            res[7*i +: 7] = ENC[int'(work % radix)];
            if (bz && i > 0 && mag < pw) res[7*i +: 7] = 7'b1111111;
            work = work / radix;
            pw   = pw * radix;
        end
        ovf = (work != 0);
        if (ovf) res = {DIGITS{7'b1111110}};
        sn = !neg;
        return res;
    endfunction

    task automatic convert(input logic [WIDTH-1:0] n, input bit hx, input bit sg,
                           input bit bz, input string tag);
        logic [7*DIGITS-1:0] exp_segs, prev_segs;
        bit exp_ovf, exp_sn, seen;
        int cyc;
        exp_segs = model(n, hx, sg, bz, exp_ovf, exp_sn);

        @(negedge clk);
        check({tag, " ready_idle"}, 64'(in_ready), 64'd1);
        prev_segs   = segs;
        num         = n;
        hex_mode    = hx;
        signed_mode = sg;
        blank_lz    = bz;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        // Scramble the inputs: the conversion must use the values captured at accept.
        in_valid    = 1'b0;
        num         = $urandom;
        hex_mode    = 1'($urandom_range(0, 1));
        signed_mode = 1'($urandom_range(0, 1));
        blank_lz    = 1'($urandom_range(0, 1));
        check({tag, " busy_ready"}, 64'(in_ready), 64'd0);

        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid) begin
                seen = 1'b1;
            end else begin
                check({tag, " segs_hold"}, 64'(segs), 64'(prev_segs));
                in_valid = (cyc < 6) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        in_valid = 1'b0;

        check({tag, " latency"}, seen ? 64'(cyc) : 64'hFFFF, 64'(hx ? LAT_HEX : LAT_DEC));
        check({tag, " segs"}, 64'(segs), 64'(exp_segs));
        check({tag, " sign_n"}, 64'(sign_n), 64'(exp_sn));
        check({tag, " overflow"}, 64'(overflow), 64'(exp_ovf));
        check({tag, " ready_during_valid"}, 64'(in_ready), 64'd0);

        @(posedge clk);
        #1;
        check({tag, " valid_pulse"}, 64'(out_valid), 64'd0);
        check({tag, " ready_after"}, 64'(in_ready), 64'd1);
        check({tag, " segs_after"}, 64'(segs), 64'(exp_segs));
    endtask

    initial begin
        logic [WIDTH-1:0] n;
        int pulses;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        num         = '0;
        hex_mode    = 1'b0;
        signed_mode = 1'b0;
        blank_lz    = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset segs", 64'(segs), {8'h00, {DIGITS{7'b1111111}}});
        check("reset sign_n", 64'(sign_n), 64'd1);
        check("reset overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset in_ready", 64'(in_ready), 64'd1);

        convert(-32'sd1234, 1'b0, 1'b1, 1'b1, "dec_m1234");
        check("dec_m1234 low4", 64'(segs[27:0]),
              64'({7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}));
        check("dec_m1234 high4", 64'(segs[55:28]), 64'({4{7'b1111111}}));

        convert(32'hDEADBEEF, 1'b1, 1'b0, 1'b0, "hex_deadbeef");
        check("hex_deadbeef const", 64'(segs),
              64'({7'b1000010, 7'b0110000, 7'b0001000, 7'b1000010,
                   7'b1100000, 7'b0110000, 7'b0110000, 7'b0111000}));

        convert(32'd100000000, 1'b0, 1'b0, 1'b0, "dec_1e8_ovf");
        check("dec_1e8_ovf const", 64'(segs), 64'({DIGITS{7'b1111110}}));

        convert(32'h80000000, 1'b0, 1'b1, 1'b0, "dec_minint");
        convert(32'd0, 1'b0, 1'b0, 1'b1, "dec_zero_blz");
        check("dec_zero_blz const", 64'(segs), 64'({{7{7'b1111111}}, 7'b0000001}));
        convert(32'd99999999, 1'b0, 1'b0, 1'b1, "dec_max_fit");
        convert(32'd0, 1'b1, 1'b1, 1'b0, "hex_zero");
        convert(32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, "hex_m1");
        convert(32'h00000100, 1'b1, 1'b0, 1'b1, "hex_100_blz");
        convert(32'd10, 1'b0, 1'b0, 1'b1, "dec_10_blz");

        for (int k = 0; k < 30; k++) begin
            n = WIDTH'($urandom) >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) n = ~n + 32'd1;
            convert(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), "random");
        end

        // Abandon a decimal conversion with reset; a busy-time request must be ignored.
        @(negedge clk);
        num         = 32'd123456789;
        hex_mode    = 1'b0;
        signed_mode = 1'b0;
        blank_lz    = 1'b0;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        num      = 32'd7;
        in_valid = 1'b1;
        check("rst busy_ready_c50", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pulses   = 0;
        for (int c = 51; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        rst_n = 1'b0;
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst segs", 64'(segs), 64'({DIGITS{7'b1111111}}));
        check("rst sign_n", 64'(sign_n), 64'd1);
        check("rst overflow", 64'(overflow), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst in_ready", 64'(in_ready), 64'd1);
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("rst no_out_valid", 64'(pulses), 64'd0);
        check("rst segs_held", 64'(segs), 64'({DIGITS{7'b1111111}}));

        convert(32'd42, 1'b0, 1'b0, 1'b0, "dec_42_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
